// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: issues sequential fetches to a synchronous
// instruction memory with valid/ready handoff to decode and branch redirects.
// Optional misaligned-redirect trap is enabled by defining IFU_MISALIGN_CHECK_EN.
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_rden_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] fetch_cnt_o,
    output logic        misalign_o
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_fetch_pc;
    logic [31:0] w_fetch_pc_nxt;
    logic        r_inflight_v;
    logic        w_inflight_v_nxt;
    logic [31:0] r_inflight_pc;
    logic [31:0] w_inflight_pc_nxt;
    logic [31:0] r_fetch_cnt;

    logic        w_valid;
    logic        w_xfer;
    logic        w_issue;
    logic        w_misalign_bad;
    logic [31:0] w_redir_pc;

`ifdef IFU_MISALIGN_CHECK_EN
    logic        r_misalign;

    assign w_misalign_bad = redirect_i && (redirect_pc_i[1:0] != 2'b00);
    assign w_redir_pc     = redirect_pc_i;
    assign misalign_o     = r_misalign;

    // Sticky misalign flag, cleared only by reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_misalign <= 1'b0;
        end else if (w_misalign_bad && (r_state != HALT)) begin
            r_misalign <= 1'b1;
        end else begin
            r_misalign <= r_misalign;
        end
    end
`else
    assign w_misalign_bad = 1'b0;
    assign w_redir_pc     = redirect_pc_i & 32'hFFFF_FFFC;
    assign misalign_o     = 1'b0;
`endif

    assign w_valid       = r_inflight_v && (r_state == RUN) && !redirect_i;
    assign w_xfer        = w_valid && instr_ready_i;
    assign w_issue       = !r_inflight_v || instr_ready_i;
    assign instr_valid_o = w_valid;
    assign instr_o       = w_valid ? imem_data_i : NOP;
    assign pc_o          = r_inflight_pc;
    assign fetch_cnt_o   = r_fetch_cnt;

    // Next-state, fetch issue and in-flight tracking
    always_comb begin
        w_state_nxt       = r_state;
        w_fetch_pc_nxt    = r_fetch_pc;
        w_inflight_v_nxt  = r_inflight_v;
        w_inflight_pc_nxt = r_inflight_pc;
        imem_rden_o       = 1'b0;
        imem_addr_o       = r_fetch_pc;
        case (r_state)
            BOOT: begin
                w_state_nxt = RUN;
                if (redirect_i) begin
                    if (w_misalign_bad) begin
                        w_state_nxt = HALT;
                    end else begin
                        w_fetch_pc_nxt = w_redir_pc;
                    end
                end else begin
                    w_fetch_pc_nxt = r_fetch_pc;
                end
            end
            RUN: begin
                if (redirect_i) begin
                    if (w_misalign_bad) begin
                        w_state_nxt      = HALT;
                        w_inflight_v_nxt = 1'b0;
                    end else begin
                        imem_rden_o       = 1'b1;
                        imem_addr_o       = w_redir_pc;
                        w_inflight_pc_nxt = w_redir_pc;
                        w_inflight_v_nxt  = 1'b1;
                        w_fetch_pc_nxt    = w_redir_pc + 32'd4;
                    end
                end else if (w_issue) begin
                    imem_rden_o       = 1'b1;
                    imem_addr_o       = r_fetch_pc;
                    w_inflight_pc_nxt = r_fetch_pc;
                    w_inflight_v_nxt  = 1'b1;
                    w_fetch_pc_nxt    = r_fetch_pc + 32'd4;
                end else if (w_xfer) begin
                    w_inflight_v_nxt = 1'b0;
                end else begin
                    w_inflight_v_nxt = r_inflight_v;
                end
            end
            HALT: begin
                w_inflight_v_nxt = 1'b0;
            end
            default: begin
                w_state_nxt      = BOOT;
                w_inflight_v_nxt = 1'b0;
            end
        endcase
    end

    // State and fetch bookkeeping registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= BOOT;
            r_fetch_pc    <= RESET_PC;
            r_inflight_pc <= RESET_PC;
            r_inflight_v  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_fetch_pc    <= w_fetch_pc_nxt;
            r_inflight_pc <= w_inflight_pc_nxt;
            r_inflight_v  <= w_inflight_v_nxt;
        end
    end

    // Count of instructions handed to decode
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fetch_cnt <= 32'd0;
        end else if (w_xfer) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end else begin
            r_fetch_cnt <= r_fetch_cnt;
        end
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl with a synchronous memory model whose word
// at address A is A + 32'h1000_0000.
module tb_ifetch_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        imem_rden_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] fetch_cnt_o;
    logic        misalign_o;

    int n_chk  = 0;
    int n_fail = 0;

    ifetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .imem_rden_o  (imem_rden_o),
        .imem_addr_o  (imem_addr_o),
        .imem_data_i  (imem_data_i),
        .instr_o      (instr_o),
        .pc_o         (pc_o),
        .instr_valid_o(instr_valid_o),
        .instr_ready_i(instr_ready_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .fetch_cnt_o  (fetch_cnt_o),
        .misalign_o   (misalign_o)
    );

    always #5 clk_i = ~clk_i;

    // Synchronous memory: data updates only on an rden-high edge
    always @(posedge clk_i) begin
        if (imem_rden_o) imem_data_i <= imem_addr_o + 32'h1000_0000;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] pc,
                           input logic [31:0] ins, input logic [31:0] cnt);
        chk({tag, "_valid"}, {31'd0, instr_valid_o}, {31'd0, v});
        chk({tag, "_pc"}, pc_o, pc);
        chk({tag, "_instr"}, instr_o, ins);
        chk({tag, "_cnt"}, fetch_cnt_o, cnt);
    endtask

    task automatic chk_mem(input string tag, input logic rd, input logic [31:0] addr);
        chk({tag, "_rden"}, {31'd0, imem_rden_o}, {31'd0, rd});
        chk({tag, "_addr"}, imem_addr_o, addr);
    endtask

    initial begin
        imem_data_i   = 32'h0;
        rst_i         = 1'b1;
        instr_ready_i = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        #12;
        chk_out("rst", 1'b0, 32'h0, 32'h0000_0013, 32'd0);
        chk_mem("rst", 1'b0, 32'h0);
        chk("rst_mis", {31'd0, misalign_o}, 32'd0);
        #10;
        rst_i = 1'b0;
        #1;
        // BOOT cycle
        chk_mem("boot", 1'b0, 32'h0);
        chk_out("boot", 1'b0, 32'h0, 32'h0000_0013, 32'd0);
        step();
        chk_mem("run1", 1'b1, 32'h0);
        chk("run1_valid", {31'd0, instr_valid_o}, 32'd0);
        step();
        chk_out("seq0", 1'b1, 32'h0, 32'h1000_0000, 32'd0);
        chk_mem("seq0", 1'b1, 32'h4);
        step();
        chk_out("seq4", 1'b1, 32'h4, 32'h1000_0004, 32'd1);
        step();
        chk_out("seq8", 1'b1, 32'h8, 32'h1000_0008, 32'd2);
        // Stall three cycles at pc 8
        instr_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_mem("stall8", 1'b0, 32'hC);
            chk_out("stall8", 1'b1, 32'h8, 32'h1000_0008, 32'd2);
            step();
        end
        instr_ready_i = 1'b1;
        #1;
        chk_mem("rel8", 1'b1, 32'hC);
        chk_out("rel8", 1'b1, 32'h8, 32'h1000_0008, 32'd2);
        step();
        chk_out("seq12", 1'b1, 32'hC, 32'h1000_000C, 32'd3);
        step();
        chk_out("seq16", 1'b1, 32'h10, 32'h1000_0010, 32'd4);
        step();
        chk_out("seq20", 1'b1, 32'h14, 32'h1000_0014, 32'd5);
        // Stall at 20, then redirect to 0x100 while still stalled
        instr_ready_i = 1'b0;
        #1;
        chk_mem("stall20", 1'b0, 32'h18);
        step();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0100;
        #1;
        chk_mem("redir", 1'b1, 32'h100);
        chk("redir_valid", {31'd0, instr_valid_o}, 32'd0);
        step();
        redirect_i    = 1'b0;
        instr_ready_i = 1'b1;
        #1;
        chk_out("tgt100", 1'b1, 32'h100, 32'h1000_0100, 32'd5);
        chk_mem("tgt100", 1'b1, 32'h104);
        step();
        chk_out("seq104", 1'b1, 32'h104, 32'h1000_0104, 32'd6);
        // Redirect near the top of the address space to exercise wrap
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFF8;
        #1;
        chk_mem("redirw", 1'b1, 32'hFFFF_FFF8);
        step();
        redirect_i = 1'b0;
        #1;
        chk_out("wrapF8", 1'b1, 32'hFFFF_FFF8, 32'h0FFF_FFF8, 32'd6);
        step();
        chk_out("wrapFC", 1'b1, 32'hFFFF_FFFC, 32'h0FFF_FFFC, 32'd7);
        step();
        chk_out("wrap0", 1'b1, 32'h0, 32'h1000_0000, 32'd8);
        chk_mem("wrap0", 1'b1, 32'h4);
        // Misaligned redirect
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0102;
        #1;
`ifdef IFU_MISALIGN_CHECK_EN
        chk_mem("mis", 1'b0, 32'h4);
        step();
        redirect_i = 1'b0;
        #1;
        chk("mis_flag", {31'd0, misalign_o}, 32'd1);
        chk_mem("halt", 1'b0, 32'h4);
        chk("halt_valid", {31'd0, instr_valid_o}, 32'd0);
        step();
        chk_mem("halt2", 1'b0, 32'h4);
        chk("mis_flag2", {31'd0, misalign_o}, 32'd1);
`else
        chk_mem("mis", 1'b1, 32'h100);
        step();
        redirect_i = 1'b0;
        #1;
        chk("mis_flag", {31'd0, misalign_o}, 32'd0);
        chk_out("mis100", 1'b1, 32'h100, 32'h1000_0100, 32'd8);
`endif
        // Asynchronous reset mid-cycle
        #2;
        rst_i = 1'b1;
        #1;
        chk_out("arst", 1'b0, 32'h0, 32'h0000_0013, 32'd0);
        chk_mem("arst", 1'b0, 32'h0);
        chk("arst_mis", {31'd0, misalign_o}, 32'd0);
        step();
        rst_i = 1'b0;
        #1;
        chk_out("post", 1'b0, 32'h0, 32'h0000_0013, 32'd0);
        step();
        chk("post_cnt", fetch_cnt_o, 32'd0);
        chk("post_valid", {31'd0, instr_valid_o}, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
